// File: rtl/div_pkg.sv
// Shared constants for the divider scheduler: state encoding, datapath mux
// selects, the default iteration count and the per-state strobe decode.
package div_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CW    = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_TEST   = 3'd2;
  localparam logic [2:0] ST_CORR   = 3'd3;
  localparam logic [2:0] ST_SHIFT1 = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_HOLD = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;
  localparam logic [1:0] SEL_Q1   = 2'b11;

  typedef struct packed {
    logic       load;
    logic       add;
    logic       shift;
    logic       inbit;
    logic [1:0] sel;
  } dp_ctl_t;

  // Datapath strobes are a pure function of state, which keeps every output Moore.
  function automatic dp_ctl_t decode_ctl(input logic [2:0] st);
    dp_ctl_t c;
    c.load  = 1'b0;
    c.add   = 1'b0;
    c.shift = 1'b0;
    c.inbit = 1'b0;
    c.sel   = SEL_IDLE;
    case (st)
      ST_LOAD: begin
        c.load  = 1'b1;
        c.shift = 1'b1;
        c.sel   = SEL_LOAD;
      end
      ST_TEST: c.sel = SEL_HOLD;
      ST_CORR: begin
        c.add   = 1'b1;
        c.shift = 1'b1;
        c.sel   = SEL_HOLD;
      end
      ST_SHIFT1: begin
        c.shift = 1'b1;
        c.inbit = 1'b1;
        c.sel   = SEL_Q1;
      end
      default: c.sel = SEL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/div_scheduler_if.sv
// Requester and datapath-control signals of the divider scheduler.
// master = requester/datapath side, slave = scheduler.
interface div_scheduler_if;
  logic [1:0] req;
  logic       dp_sign;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic       dp_load;
  logic       dp_add;
  logic       dp_shift;
  logic       dp_inbit;
  logic [1:0] dp_sel;

  modport master (
    output req, dp_sign,
    input  gnt, done, busy, dp_load, dp_add, dp_shift, dp_inbit, dp_sel
  );

  modport slave (
    input  req, dp_sign,
    output gnt, done, busy, dp_load, dp_add, dp_shift, dp_inbit, dp_sel
  );
endinterface

// File: rtl/div_scheduler_rr_arb2.sv
// Two-way round-robin pick; combinational, registered by div_scheduler.
// last names the requester served most recently; the other one wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick,
  output logic       idx
);

  always_comb begin
    pick = 2'b00;
    idx  = 1'b0;
    case (req)
      2'b01: begin
        pick = 2'b01;
        idx  = 1'b0;
      end
      2'b10: begin
        pick = 2'b10;
        idx  = 1'b1;
      end
      2'b11: begin
        idx  = ~last;
        pick = last ? 2'b01 : 2'b10;
      end
      default: begin
        pick = 2'b00;
        idx  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/div_scheduler.sv
// Round-robin scheduler and sequencer for the shared shift/add divider:
// one LOAD, then WIDTH iterations of TEST followed by CORR or SHIFT1, then DONE.
//
// state  | meaning
// IDLE   | no grant; arbitrate pending requests
// LOAD   | load operands, first shift
// TEST   | sample dp_sign for the current iteration
// CORR   | remainder negative: restore and shift, quotient bit 0
// SHIFT1 | remainder non-negative: shift in quotient bit 1
// DONE   | one-cycle completion pulse to the granted requester
module div_scheduler
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic            clk,
  input  logic            reset,
  div_scheduler_if.slave  bus
);

  logic [2:0]    state;
  logic [CW-1:0] count;
  logic          last;
  logic          idx;
  logic [1:0]    gnt_q;
  logic [1:0]    arb_pick;
  logic          arb_idx;
  logic          hold;
  dp_ctl_t       ctl;

  rr_arb2 u_arb (
    .req  (bus.req),
    .last (last),
    .pick (arb_pick),
    .idx  (arb_idx)
  );

  // Owner still requesting; dropping it mid-divide aborts back to IDLE.
  assign hold = bus.req[idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
      last  <= 1'b1;
      idx   <= 1'b0;
      gnt_q <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req != 2'b00) begin
            state <= ST_LOAD;
            idx   <= arb_idx;
            gnt_q <= arb_pick;
            count <= '0;
          end
        end
        ST_LOAD, ST_TEST: begin
          if (!hold) begin
            state <= ST_IDLE;
            last  <= idx;
            gnt_q <= 2'b00;
          end else if (state == ST_LOAD) begin
            state <= ST_TEST;
          end else begin
            state <= bus.dp_sign ? ST_CORR : ST_SHIFT1;
          end
        end
        ST_CORR, ST_SHIFT1: begin
          if (!hold) begin
            state <= ST_IDLE;
            last  <= idx;
            gnt_q <= 2'b00;
          end else begin
            count <= count + CW'(1);
            state <= (count == CW'(WIDTH - 1)) ? ST_DONE : ST_TEST;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          last  <= idx;
          gnt_q <= 2'b00;
        end
        default: begin
          state <= ST_IDLE;
          gnt_q <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    ctl          = decode_ctl(state);
    bus.gnt      = gnt_q;
    bus.done     = (state == ST_DONE) ? gnt_q : 2'b00;
    bus.busy     = (state != ST_IDLE);
    bus.dp_load  = ctl.load;
    bus.dp_add   = ctl.add;
    bus.dp_shift = ctl.shift;
    bus.dp_inbit = ctl.inbit;
    bus.dp_sel   = ctl.sel;
  end

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: vector table of divides, hand-written reset/abort
// sequences, then random divides checked against a per-cycle schedule model.
module tb_div_scheduler;

  localparam int W  = 8;
  localparam int CW = 4;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  int   last_ref;

  div_scheduler_if bus ();

  div_scheduler #(.WIDTH(W), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   r;
    logic [W-1:0] signs;
    int           abort_t;
    logic [1:0]   after;
    int           w;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [10:0] pack_out();
    return {bus.gnt, bus.done, bus.busy, bus.dp_load, bus.dp_add,
            bus.dp_shift, bus.dp_inbit, bus.dp_sel};
  endfunction

  // Expected outputs t cycles after the granting edge: t=0 load, odd t test,
  // even t the shift for iteration (t-2)/2, t=2W+1 done.
  function automatic logic [10:0] exp_vec(input int w, input int t, input logic [W-1:0] s);
    logic [1:0] g, dn, sel;
    logic ld, ad, sh, ib;
    g = 2'(1 << w);
    dn = 2'b00; sel = 2'b00; ld = 0; ad = 0; sh = 0; ib = 0;
    if (t == 0) begin
      ld = 1; sh = 1; sel = 2'b10;
    end else if (t == 2*W+1) begin
      dn = g;
    end else if ((t % 2) == 1) begin
      sel = 2'b01;
    end else if (s[(t-2)/2]) begin
      ad = 1; sh = 1; sel = 2'b01;
    end else begin
      sh = 1; ib = 1; sel = 2'b11;
    end
    return {g, dn, 1'b1, ld, ad, sh, ib, sel};
  endfunction

  function automatic int model_pick(input logic [1:0] r, input int last);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    return (last == 1) ? 0 : 1;
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Entered at a negedge with the DUT idle; leaves at the negedge of the
  // IDLE cycle that follows DONE or the abort.
  task automatic do_div(input logic [1:0] r, input logic [W-1:0] s, input int abort_t,
                        input logic [1:0] after, input int w, input string tag);
    logic [1:0] m;
    m = 2'(1 << w);
    bus.req = r;
    bus.dp_sign = 1'($urandom_range(0, 1));
    for (int t = 0; t <= 2*W+1; t++) begin
      @(negedge clk);
      check($sformatf("%s t%0d", tag, t), pack_out(), exp_vec(w, t, s));
      if ((t % 2) == 1 && t <= 2*W-1) bus.dp_sign = s[(t-1)/2];
      else bus.dp_sign = 1'($urandom_range(0, 1));
      if (t == abort_t) begin
        bus.req = r & ~m;
        @(negedge clk);
        check($sformatf("%s abort idle", tag), pack_out(), 11'd0);
        last_ref = w;
        return;
      end
      if (t == 2*W+1) bus.req = after;
    end
    @(negedge clk);
    check($sformatf("%s post idle", tag), pack_out(), 11'd0);
    last_ref = w;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    last_ref = 1;

    tbl[0] = '{2'b11, 8'h00, -1, 2'b00, 0};
    tbl[1] = '{2'b10, 8'h00, -1, 2'b00, 1};
    tbl[2] = '{2'b01, 8'h55, -1, 2'b11, 0};
    tbl[3] = '{2'b11, 8'hA3, -1, 2'b11, 1};
    tbl[4] = '{2'b11, 8'h0F, -1, 2'b00, 0};
    tbl[5] = '{2'b11, 8'h3C,  5, 2'b00, 1};
    tbl[6] = '{2'b11, 8'hFF, -1, 2'b00, 0};
    tbl[7] = '{2'b01, 8'h12,  0, 2'b00, 0};
    tbl[8] = '{2'b11, 8'h99, 16, 2'b00, 1};
    tbl[9] = '{2'b10, 8'h81, -1, 2'b00, 1};

    reset = 1'b0;
    bus.req = 2'b11;
    bus.dp_sign = 1'b0;
    #1;
    check("reset async", pack_out(), 11'd0);
    repeat (3) begin
      @(negedge clk);
      check("reset held", pack_out(), 11'd0);
    end
    reset = 1'b1;

    for (int i = 0; i < 10; i++)
      do_div(tbl[i].r, tbl[i].signs, tbl[i].abort_t, tbl[i].after, tbl[i].w,
             $sformatf("vec%0d", i));

    // Reset pulled in the middle of a CORR cycle.
    bus.req = 2'b01;
    @(negedge clk);
    check("rst load", pack_out(), exp_vec(0, 0, 8'h01));
    @(negedge clk);
    check("rst test", pack_out(), exp_vec(0, 1, 8'h01));
    bus.dp_sign = 1'b1;
    @(negedge clk);
    check("rst corr", pack_out(), exp_vec(0, 2, 8'h01));
    #2 reset = 1'b0;
    #1 check("rst mid corr", pack_out(), 11'd0);
    bus.req = 2'b00;
    @(negedge clk);
    check("rst low", pack_out(), 11'd0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst idle no req", pack_out(), 11'd0);
    end
    last_ref = 1;
    do_div(2'b11, 8'h6B, -1, 2'b00, 0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   r;
      logic [W-1:0] s;
      int           ab;
      r  = 2'($urandom_range(1, 3));
      s  = W'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2*W)) : -1;
      do_div(r, s, ab, 2'($urandom_range(0, 3)), model_pick(r, last_ref),
             $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
